// File: rtl/t_flip_flop.sv
// Toggle flip-flop with asynchronous active-low clear; one stage of the ripple chain.
module t_flip_flop (
  input  logic clk,
  input  logic Reset,
  input  logic t,
  output logic q
);

  // Toggle storage: inverts on a clock edge when t is set, cleared by Reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/ripple_down_top.sv
// N-bit ripple down-counter with a Clock-synchronous view of the count,
// a zero flag and registered wrap (borrow-out) detection and counting.
module ripple_down_top #(
  parameter int N      = 4,
  parameter int WRAP_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  output logic [N-1:0]      outBus,
  output logic [N-1:0]      outSync,
  output logic              zero,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrapCount
);

  localparam logic [N-1:0]      ALL_ONES = {N{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  logic [N-1:0]      stage_q_s;
  logic [N-1:0]      sync_r;
  logic              prev_zero_r;
  logic              wrap_r;
  logic [WRAP_W-1:0] wrap_count_r;
  logic              wrap_set_s;

  // Rising edge of the previous stage clocks the next one, which makes the chain count down.
  for (genvar i = 0; i < N; i++) begin : g_stage
    if (i == 0) begin : g_lsb
      t_flip_flop u_tff (
        .clk   (Clock),
        .Reset (Reset),
        .t     (Enable),
        .q     (stage_q_s[i])
      );
    end else begin : g_upper
      t_flip_flop u_tff (
        .clk   (stage_q_s[i-1]),
        .Reset (Reset),
        .t     (1'b1),
        .q     (stage_q_s[i])
      );
    end
  end

  // A wrap is the captured count moving from 0 straight to all-ones.
  always_comb begin
    wrap_set_s = 1'b0;
    if (prev_zero_r && (sync_r == ALL_ONES)) begin
      wrap_set_s = 1'b1;
    end else begin
      wrap_set_s = 1'b0;
    end
  end

  // Synchronous capture of the settled ripple count and wrap bookkeeping.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_r       <= {N{1'b0}};
      prev_zero_r  <= 1'b0;
      wrap_r       <= 1'b0;
      wrap_count_r <= {WRAP_W{1'b0}};
    end else begin
      sync_r      <= stage_q_s;
      prev_zero_r <= (sync_r == {N{1'b0}});
      wrap_r      <= wrap_set_s;
      if (wrap_set_s) begin
        wrap_count_r <= wrap_count_r + WRAP_ONE;
      end else begin
        wrap_count_r <= wrap_count_r;
      end
    end
  end

  assign outBus    = stage_q_s;
  assign outSync   = sync_r;
  assign zero      = (sync_r == {N{1'b0}});
  assign wrap      = wrap_r;
  assign wrapCount = wrap_count_r;

endmodule

// File: tb/tb_ripple_down_top.sv
// Self-checking bench for ripple_down_top: three instances (N=4/W=8, N=4/W=2, N=8/W=8)
// driven together, checked against a cycle model through a scoreboard queue.
module tb_ripple_down_top;

  logic       Clock;
  logic       Reset;
  logic       Enable;
  logic [3:0] bus_a, sync_a, bus_b, sync_b;
  logic [7:0] bus_c, sync_c;
  logic       zero_a, zero_b, zero_c, wrap_a, wrap_b, wrap_c;
  logic [7:0] wcnt_a, wcnt_c;
  logic [1:0] wcnt_b;

  ripple_down_top #(.N(4), .WRAP_W(8)) dut_a (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .outBus(bus_a), .outSync(sync_a),
    .zero(zero_a), .wrap(wrap_a), .wrapCount(wcnt_a));
  ripple_down_top #(.N(4), .WRAP_W(2)) dut_b (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .outBus(bus_b), .outSync(sync_b),
    .zero(zero_b), .wrap(wrap_b), .wrapCount(wcnt_b));
  ripple_down_top #(.N(8), .WRAP_W(8)) dut_c (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .outBus(bus_c), .outSync(sync_c),
    .zero(zero_c), .wrap(wrap_c), .wrapCount(wcnt_c));

  typedef struct {
    logic [7:0] bus;
    logic [7:0] sync;
    logic       zero;
    logic       wrap;
    logic [7:0] wcnt;
  } exp_t;

  typedef struct {
    logic       en;
    logic [3:0] bus;
    logic [3:0] sync;
    logic       zero;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[20];

  logic [7:0] mask_bus [3];
  logic [7:0] mask_w   [3];
  logic [7:0] m_bus    [3];
  logic [7:0] m_sync   [3];
  logic       m_pz     [3];
  logic       m_wrap   [3];
  logic [7:0] m_wcnt   [3];

  int passed = 0;
  int total  = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic get_act(input int i, output exp_t a);
    case (i)
      0: begin
        a.bus = {4'h0, bus_a}; a.sync = {4'h0, sync_a}; a.zero = zero_a;
        a.wrap = wrap_a; a.wcnt = wcnt_a;
      end
      1: begin
        a.bus = {4'h0, bus_b}; a.sync = {4'h0, sync_b}; a.zero = zero_b;
        a.wrap = wrap_b; a.wcnt = {6'h00, wcnt_b};
      end
      default: begin
        a.bus = bus_c; a.sync = sync_c; a.zero = zero_c;
        a.wrap = wrap_c; a.wcnt = wcnt_c;
      end
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_bus[i] = 8'h00; m_sync[i] = 8'h00; m_pz[i] = 1'b0;
      m_wrap[i] = 1'b0; m_wcnt[i] = 8'h00;
    end
  endtask

  task automatic model_edge(input logic en);
    logic nw;
    for (int i = 0; i < 3; i++) begin
      nw = m_pz[i] && (m_sync[i] == mask_bus[i]);
      if (nw) m_wcnt[i] = (m_wcnt[i] + 8'h01) & mask_w[i];
      m_wrap[i] = nw;
      m_pz[i]   = (m_sync[i] == 8'h00);
      m_sync[i] = m_bus[i];
      if (en) m_bus[i] = (m_bus[i] - 8'h01) & mask_bus[i];
    end
  endtask

  task automatic compare_one(input int i, input exp_t e);
    exp_t a;
    string s;
    get_act(i, a);
    s = $sformatf("%0d", i);
    check({"bus", s},  a.bus,  e.bus);
    check({"sync", s}, a.sync, e.sync);
    check({"zero", s}, {7'h00, a.zero}, {7'h00, e.zero});
    check({"wrap", s}, {7'h00, a.wrap}, {7'h00, e.wrap});
    check({"wcnt", s}, a.wcnt, e.wcnt);
  endtask

  // One Clock cycle: drive at negedge, model at posedge, compare at the following negedge.
  task automatic cycle(input logic en);
    exp_t e;
    Enable = en;
    @(posedge Clock);
    if (Reset) model_edge(en);
    for (int i = 0; i < 3; i++) begin
      e.bus = m_bus[i]; e.sync = m_sync[i]; e.zero = (m_sync[i] == 8'h00);
      e.wrap = m_wrap[i]; e.wcnt = m_wcnt[i];
      exp_q.push_back(e);
    end
    @(negedge Clock);
    for (int i = 0; i < 3; i++) begin
      compare_one(i, exp_q.pop_front());
    end
  endtask

  task automatic check_reset_state(input string tag);
    exp_t a;
    for (int i = 0; i < 3; i++) begin
      get_act(i, a);
      check({tag, "_bus"},  a.bus,  8'h00);
      check({tag, "_sync"}, a.sync, 8'h00);
      check({tag, "_zero"}, {7'h00, a.zero}, 8'h01);
      check({tag, "_wrap"}, {7'h00, a.wrap}, 8'h00);
      check({tag, "_wcnt"}, a.wcnt, 8'h00);
    end
  endtask

  // Assert Reset between edges, hold it across one posedge, release at a negedge.
  task automatic pulse_reset(input string tag);
    #2 Reset = 1'b0;
    #1 check_reset_state(tag);
    model_reset();
    @(negedge Clock);
    cycle(1'b1);
    Reset = 1'b1;
  endtask

  initial begin
    int pulses;
    int widx;
    logic [7:0] bseq [5];

    mask_bus[0] = 8'h0F; mask_bus[1] = 8'h0F; mask_bus[2] = 8'hFF;
    mask_w[0]   = 8'hFF; mask_w[1]   = 8'h03; mask_w[2]   = 8'hFF;
    bseq[0] = 8'h01; bseq[1] = 8'h02; bseq[2] = 8'h03; bseq[3] = 8'h00; bseq[4] = 8'h01;

    for (int k = 0; k < 20; k++) begin
      tbl[k].en   = 1'b1;
      tbl[k].bus  = 4'((32 - (k + 1)) % 16);
      tbl[k].sync = 4'((32 - k) % 16);
      tbl[k].zero = (((32 - k) % 16) == 0);
    end

    Reset  = 1'b0;
    Enable = 1'b1;
    model_reset();
    #3 check_reset_state("rst0");
    @(negedge Clock);
    Reset = 1'b1;

    for (int k = 0; k < 20; k++) begin
      cycle(tbl[k].en);
      check("tbl_bus",  {4'h0, bus_a},  {4'h0, tbl[k].bus});
      check("tbl_sync", {4'h0, sync_a}, {4'h0, tbl[k].sync});
      check("tbl_zero", {7'h00, zero_a}, {7'h00, tbl[k].zero});
    end

    for (int k = 0; k < 3; k++) cycle(1'b1);
    check("at9_bus", {4'h0, bus_a}, 8'h09);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0);
      check("hold_bus",  {4'h0, bus_a},  8'h09);
      check("hold_sync", {4'h0, sync_a}, 8'h09);
      check("hold_wrap", {7'h00, wrap_a}, 8'h00);
    end
    cycle(1'b1);
    check("resume_bus", {4'h0, bus_a}, 8'h08);

    pulse_reset("rstmid");
    cycle(1'b1);
    check("restart_bus", {4'h0, bus_a}, 8'h0F);

    pulses = 0;
    widx   = 0;
    for (int k = 0; k < 67; k++) begin
      cycle(1'b1);
      if (wrap_a) begin
        pulses++;
        if (widx < 5) begin
          check("wcnt_b_seq", {6'h00, wcnt_b}, bseq[widx]);
          widx++;
        end
      end
    end
    check("wrap_pulses", 8'(pulses), 8'h05);
    check("wcnt_a_5", wcnt_a, 8'h05);

    @(negedge Clock);
    pulse_reset("rst8");
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      cycle(1'b1);
      if (wrap_c) pulses++;
    end
    check("n8_bus0", bus_c, 8'h00);
    check("n8_wcnt", wcnt_c, 8'h01);
    check("n8_pulses", 8'(pulses), 8'h01);

    for (int k = 0; k < 100; k++) begin
      cycle(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
